mcntrl_rd_gather: RTL and testbench



---
 rtl/mcntrl_pkg.sv | 11 +
 rtl/mcntrl_start_delay.sv | 42 ++++
 rtl/mcntrl_rd_gather.sv | 99 +++++++++
 tb/tb_mcntrl_rd_gather.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcntrl_pkg.sv
// Shared constants for the memory-controller read path: burst length and
// deserializer geometry.
package mcntrl_pkg;

  localparam int BL             = 8;
  localparam int SERDES_WIDTH   = 4;
  localparam int BEATS_PER_WORD = 4;
  // Beats in one memory clock: the granularity of rd_shift.
  localparam int HALF_WORD      = BEATS_PER_WORD / 2;

endpackage

// File: rtl/mcntrl_start_delay.sv
// Variable-tap delay line for accepted read starts, followed by a two-stage tap
// pipeline that marks the cycles one and two words after the first data word.
module mcntrl_start_delay #(
  parameter int LAT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [LAT_WIDTH-1:0] i_lat,
  input  logic                 i_stage2_en,
  output logic                 o_prev,
  output logic [1:0]           o_tap
);

  localparam int DEPTH = 2 ** LAT_WIDTH;

  logic [DEPTH-1:0] r_line;
  logic [DEPTH-1:0] w_taken;
  logic [DEPTH-1:0] w_line_kept;
  logic [1:0]       r_tap;

  // A start is removed from the line once tapped, so a latency change mid-flight
  // cannot make the same start hit the tap twice.
  assign w_taken     = DEPTH'(1) << i_lat;
  assign w_line_kept = r_line & ~w_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_tap  <= '0;
    end else begin
      r_line   <= {w_line_kept[DEPTH-2:0], i_start};
      r_tap[0] <= r_line[i_lat];
      // Only bursts that still need the third word advance to the second stage.
      r_tap[1] <= r_tap[0] & i_stage2_en;
    end
  end

  assign o_prev = r_line[0];
  assign o_tap  = r_tap;

endmodule

// File: rtl/mcntrl_rd_gather.sv
// Read-data gatherer for one DDR3 byte lane group: aligns deserialized words to
// issued read commands and assembles each BL8 burst into a single wide word.
module mcntrl_rd_gather
  import mcntrl_pkg::*;
#(
  parameter int NUM_DQ    = 8,
  parameter int LAT_WIDTH = 5
) (
  input  logic                           oclk_div,
  input  logic                           rst_n,
  input  logic [SERDES_WIDTH*NUM_DQ-1:0] din,
  input  logic                           rd_start,
  input  logic [LAT_WIDTH-1:0]           rd_lat,
  input  logic                           rd_shift,
  input  logic                           err_clr,
  output logic [BL*NUM_DQ-1:0]           dout,
  output logic                           dout_valid,
  output logic                           err_overlap
);

  localparam int WORD_W = SERDES_WIDTH * NUM_DQ;
  localparam int WIN_W  = 3 * SERDES_WIDTH;
  localparam int OFF_W  = $clog2(WIN_W);

  logic              w_prev_acc;
  logic              w_accept;
  logic              w_drop;
  logic              w_emit;
  logic [1:0]        w_tap;
  logic [OFF_W-1:0]  w_off;
  logic [BL*NUM_DQ-1:0] w_asm;

  logic [WORD_W-1:0]    r_hist0;
  logic [WORD_W-1:0]    r_hist1;
  logic [BL*NUM_DQ-1:0] r_dout;
  logic                 r_valid;
  logic                 r_err;

  assign w_accept = rd_start & ~w_prev_acc;
  assign w_drop   = rd_start &  w_prev_acc;

  mcntrl_start_delay #(
    .LAT_WIDTH (LAT_WIDTH)
  ) u_start_delay (
    .clk         (oclk_div),
    .rst_n       (rst_n),
    .i_start     (w_accept),
    .i_lat       (rd_lat),
    .i_stage2_en (rd_shift),
    .o_prev      (w_prev_acc),
    .o_tap       (w_tap)
  );

  // Shift 0 completes on W1 (first tap stage); shift 1 needs W2 (second stage).
  assign w_emit = rd_shift ? w_tap[1] : w_tap[0];
  assign w_off  = rd_shift ? OFF_W'(HALF_WORD) : OFF_W'(BEATS_PER_WORD);

  // Window per lane = {live word, previous, one before}; the burst sits at
  // offset 4 (W0 = previous) or offset 2 (W0 = one before, upper half).
  for (genvar gi = 0; gi < NUM_DQ; gi++) begin : g_lane
    logic [WIN_W-1:0] w_window;
    assign w_window = {din[gi*SERDES_WIDTH +: SERDES_WIDTH],
                       r_hist0[gi*SERDES_WIDTH +: SERDES_WIDTH],
                       r_hist1[gi*SERDES_WIDTH +: SERDES_WIDTH]};
    assign w_asm[gi*BL +: BL] = w_window[w_off +: BL];
  end

  always_ff @(posedge oclk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_hist0 <= '0;
      r_hist1 <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_hist0 <= din;
      r_hist1 <= r_hist0;
      r_valid <= w_emit;
      if (w_emit) begin
        r_dout <= w_asm;
      end
    end
  end

  // A dropped start wins over a coincident clear.
  always_ff @(posedge oclk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_drop) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_valid;
  assign err_overlap = r_err;

endmodule

// File: tb/tb_mcntrl_rd_gather.sv
// Scoreboard bench for mcntrl_rd_gather: a per-cycle stimulus plan drives the
// DUT, expected bursts are queued as starts are driven and matched on strobes.
module tb_mcntrl_rd_gather;

  localparam int NUM_DQ = 8;
  localparam int LAT_W  = 5;
  localparam int WW     = 4 * NUM_DQ;
  localparam int DW     = 8 * NUM_DQ;
  localparam int N      = 4096;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WW-1:0]    din;
  logic             rd_start;
  logic [LAT_W-1:0] rd_lat;
  logic             rd_shift;
  logic             err_clr;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic             err_overlap;

  mcntrl_rd_gather #(
    .NUM_DQ    (NUM_DQ),
    .LAT_WIDTH (LAT_W)
  ) dut (
    .oclk_div    (clk),
    .rst_n       (rst_n),
    .din         (din),
    .rd_start    (rd_start),
    .rd_lat      (rd_lat),
    .rd_shift    (rd_shift),
    .err_clr     (err_clr),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .err_overlap (err_overlap)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] din_plan [N];
  bit            st_plan  [N];
  bit            clr_plan [N];
  bit            rst_plan [N];
  bit            fix_plan [N];
  logic [63:0]   fix_data [N];

  exp_t        q[$];
  int          cyc;
  int          checks;
  int          failures;
  int          acc_cnt;
  int          str_cnt;
  bit          prev_acc;
  bit          err_vis;
  bit          err_pend;
  logic [63:0] hold;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Per lane: shift 0 -> {W1, W0}; shift 1 -> {W2[1:0], W1, W0[3:2]}.
  function automatic logic [63:0] ref_burst(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                                            input logic [WW-1:0] w2, input bit sh);
    logic [63:0] r;
    logic [3:0]  a, b, c;
    r = '0;
    for (int i = 0; i < NUM_DQ; i++) begin
      a = w0[4*i +: 4];
      b = w1[4*i +: 4];
      c = w2[4*i +: 4];
      if (sh) r[8*i +: 8] = {c[1:0], b, a[3:2]};
      else    r[8*i +: 8] = {b, a};
    end
    return r;
  endfunction

  task automatic step();
    exp_t e;
    bit   acc;
    bit   drop;
    int   c0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n    = !rst_plan[cyc];
    rd_start = st_plan[cyc];
    err_clr  = clr_plan[cyc];
    din      = din_plan[cyc];
    if (rst_plan[cyc]) begin
      q.delete();
      prev_acc = 0;
      err_vis  = 0;
      err_pend = 0;
      hold     = '0;
    end else begin
      err_vis = err_pend;
      acc  = rd_start && !prev_acc;
      drop = rd_start &&  prev_acc;
      if (acc) begin
        c0     = cyc + int'(rd_lat) + 1;
        e.cyc  = c0 + 2 + int'(rd_shift);
        e.data = fix_plan[cyc] ? fix_data[cyc]
                               : ref_burst(din_plan[c0], din_plan[c0+1], din_plan[c0+2], rd_shift);
        q.push_back(e);
        acc_cnt++;
      end
      err_pend = drop ? 1'b1 : (err_clr ? 1'b0 : err_vis);
      prev_acc = acc;
    end
    @(negedge clk);
    if (dout_valid) begin
      str_cnt++;
      if (q.size() == 0) begin
        check_eq("spurious_strobe", 64'(dout_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check_eq("strobe_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("burst_data", dout, e.data);
        hold = e.data;
        $display("burst cycle=%0d dout=%h", cyc, dout);
      end
    end else begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        check_eq("missed_strobe", 64'(dout_valid), 64'd1);
        void'(q.pop_front());
      end
    end
    check_eq("dout_hold", dout, hold);
    check_eq("err_overlap", 64'(err_overlap), 64'(err_vis));
  endtask

  task automatic run_until(input int last);
    while (cyc < last) step();
  endtask

  initial begin
    int base;
    int c;
    clk = 0; rst_n = 0; din = '0; rd_start = 0; err_clr = 0;
    rd_lat = 5; rd_shift = 0;
    cyc = 0; checks = 0; failures = 0; acc_cnt = 0; str_cnt = 0;
    prev_acc = 0; err_vis = 0; err_pend = 0; hold = '0;
    for (int i = 0; i < N; i++) begin
      din_plan[i] = $urandom;
      st_plan[i] = 0; clr_plan[i] = 0; rst_plan[i] = 0; fix_plan[i] = 0; fix_data[i] = '0;
    end
    for (int i = 1; i <= 3; i++) rst_plan[i] = 1;
    run_until(5);

    // Aligned burst, latency 5.
    base = cyc;
    st_plan[base+10] = 1;
    din_plan[base+16] = 32'hAAAAAAAA;
    din_plan[base+17] = 32'h55555555;
    fix_plan[base+10] = 1;
    fix_data[base+10] = 64'h5A5A5A5A5A5A5A5A;
    run_until(base + 30);
    check_eq("drain_p1", 64'(q.size()), 64'd0);

    // Half-word shifted burst, latency 3.
    rd_lat = 3; rd_shift = 1;
    base = cyc;
    st_plan[base+10] = 1;
    din_plan[base+14] = 32'hCCCCCCCC;
    din_plan[base+15] = 32'h33333333;
    din_plan[base+16] = 32'h99999999;
    fix_plan[base+10] = 1;
    fix_data[base+10] = 64'h4F4F4F4F4F4F4F4F;
    run_until(base + 30);
    check_eq("drain_p2", 64'(q.size()), 64'd0);

    // Latency 0, shifted, back-to-back sharing a boundary word.
    rd_lat = 0; rd_shift = 1;
    base = cyc;
    st_plan[base+4] = 1;
    st_plan[base+6] = 1;
    run_until(base + 20);
    check_eq("drain_p3", 64'(q.size()), 64'd0);

    // Overlap detection and clear priority.
    rd_lat = 2; rd_shift = 0;
    base = cyc;
    st_plan[base+20] = 1; st_plan[base+21] = 1;
    clr_plan[base+30] = 1;
    st_plan[base+40] = 1; st_plan[base+41] = 1; clr_plan[base+41] = 1;
    clr_plan[base+50] = 1;
    run_until(base + 60);
    check_eq("drain_p4", 64'(q.size()), 64'd0);

    // Max latency burst discarded by a reset while in flight.
    rd_lat = 31; rd_shift = 0;
    base = cyc;
    st_plan[base+1] = 1;
    for (int i = 16; i <= 18; i++) rst_plan[base+i] = 1;
    run_until(base + 90);
    check_eq("drain_p5", 64'(q.size()), 64'd0);

    // Random streams, one per shift setting.
    for (int r = 0; r < 2; r++) begin
      rd_lat = LAT_W'($urandom_range(0, 31));
      rd_shift = r[0];
      acc_cnt = 0; str_cnt = 0;
      base = cyc;
      c = base + 2;
      for (int k = 0; k < 200; k++) begin
        st_plan[c] = 1;
        c += $urandom_range(2, 4);
      end
      run_until(c + 40);
      check_eq("strobe_count", 64'(str_cnt), 64'(acc_cnt));
      check_eq("drain_rand", 64'(q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
